// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller.
//   DATA_W_DEF : default data/address width
//   state_t    : controller FSM state encoding
package mem_stage_ctrl_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HELD = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_timer.sv
// Outstanding-request timer for the MEM-stage controller.
// Counts cycles while en is high and flags the cycle in which the
// TIMEOUT-th enabled cycle is reached. TIMEOUT = 0 disables the check.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clr     : synchronous clear of the count
//   en      : count this cycle (request outstanding)
//   expired : high during the TIMEOUT-th consecutive enabled cycle
module mem_req_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      // r_cnt holds the number of enabled cycles already elapsed
      assign expired = en && (r_cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller feeding the MEM/WB register.
// Runs a req/done handshake with a multi-cycle data memory, stalls the
// upstream stages while an access is outstanding, buffers read data while
// MEM/WB is frozen, and flags misaligned accesses and memory timeouts.
//
// state | meaning
// IDLE  | no access outstanding; request driven straight from EX/MEM
// BUSY  | request outstanding, fields held in registers
// HELD  | access done while MEM/WB frozen; result replayed from buffer
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   valid, memRead, memWrite         : EX/MEM instruction qualifiers
//   addr, wrData                     : effective address, store data
//   hold_in                          : downstream freeze of MEM/WB
//   mem_req, mem_wr, mem_addr,
//   mem_wdata                        : memory request
//   mem_done, mem_rdata              : memory completion pulse and read data
//   memData                          : load result to MEM/WB
//   stall_out                        : upstream freeze
//   err_align, err_timeout           : sticky error flags
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              hold_in,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] memData,
  output logic              stall_out,
  output logic              err_align,
  output logic              err_timeout
);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_addr, r_wdata, r_buf;
  logic              r_wr, r_err_align, r_err_timeout;
  logic              w_mem_op, w_acc, w_misalign;
  logic              w_expired, w_cap, w_set_to;

  assign w_mem_op   = valid && (memRead || memWrite);
  assign w_acc      = w_mem_op && !addr[0];
  assign w_misalign = w_mem_op && addr[0];

  mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (r_state != ST_BUSY),
    .en      (r_state == ST_BUSY),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_wr      = r_wr;
    mem_addr    = r_addr;
    mem_wdata   = r_wdata;
    memData     = '0;
    stall_out   = 1'b0;
    w_cap       = 1'b0;
    w_set_to    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem_req   = w_acc;
        mem_wr    = memWrite;
        mem_addr  = addr;
        mem_wdata = wrData;
        if (w_acc) begin
          if (mem_done) begin
            memData = memWrite ? '0 : mem_rdata;
            if (hold_in) begin
              w_cap       = 1'b1;
              w_state_nxt = ST_HELD;
            end
          end else begin
            stall_out   = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        mem_req = 1'b1;
        if (mem_done) begin
          memData = r_wr ? '0 : mem_rdata;
          if (hold_in) begin
            w_cap       = 1'b1;
            w_state_nxt = ST_HELD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_expired) begin
          // give up: the instruction retires with memData = 0
          w_set_to    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
      ST_HELD: begin
        memData   = r_buf;
        stall_out = 1'b1;
        if (!hold_in) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wr          <= 1'b0;
      r_buf         <= '0;
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_acc) begin
        r_addr  <= addr;
        r_wdata <= wrData;
        r_wr    <= memWrite;
      end
      // buffer takes the already-masked result, so a held store replays 0
      if (w_cap) r_buf <= memData;
      if (r_state == ST_IDLE && w_misalign) r_err_align <= 1'b1;
      if (w_set_to) r_err_timeout <= 1'b1;
    end
  end

  assign err_align   = r_err_align;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst, valid, memRead, memWrite, hold_in, mem_done;
  logic [DW-1:0] addr, wrData, mem_rdata;
  logic          mem_req, mem_wr, stall_out, err_align, err_timeout;
  logic [DW-1:0] mem_addr, mem_wdata, memData;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_align = 1'b0;
  bit exp_to    = 1'b0;

  mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wrData(wrData), .hold_in(hold_in),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .memData(memData),
    .stall_out(stall_out), .err_align(err_align), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one cycle: inputs already driven; check at negedge, advance past posedge
  task automatic step(input logic e_req, input logic e_stall, input logic [DW-1:0] e_md,
                      input bit f_chk, input logic e_wr, input logic [DW-1:0] e_addr,
                      input logic [DW-1:0] e_wdata);
    @(negedge clk);
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("stall_out", 32'(stall_out), 32'(e_stall));
    chk("memData", 32'(memData), 32'(e_md));
    chk("err_align", 32'(err_align), 32'(exp_align));
    chk("err_timeout", 32'(err_timeout), 32'(exp_to));
    if (f_chk) begin
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // cycle with no live memory access; stray mem_done / hold_in must be ignored
  task automatic gap();
    valid     = $urandom_range(0, 1) == 1;
    memRead   = valid ? 1'b0 : 1'($urandom_range(0, 1));
    memWrite  = valid ? 1'b0 : 1'($urandom_range(0, 1));
    addr      = DW'($urandom);
    wrData    = DW'($urandom);
    hold_in   = 1'($urandom_range(0, 1));
    mem_done  = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    idle_step();
    valid = 1'b0; mem_done = 1'b0; hold_in = 1'b0;
  endtask

  task automatic misaligned(input logic is_wr, input logic [DW-1:0] a);
    valid = 1'b1; memRead = !is_wr; memWrite = is_wr; addr = a | 16'h0001;
    wrData = DW'($urandom); hold_in = 1'b0; mem_done = 1'b0;
    idle_step();
    exp_align = 1'b1;
    valid = 1'b0;
  endtask

  // Timeline of one aligned access presented in cycle 0:
  //   lat >= 0 : mem_done in cycle lat; lat < 0 : never (times out in cycle TMO)
  //   hold_n >= 0 : hold_in high in done cycle and hold_n cycles after it
  task automatic do_access(input logic is_wr, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rdat, input int lat, input int hold_n);
    logic [DW-1:0] res;
    logic          dn, to;
    res = is_wr ? '0 : rdat;
    valid = 1'b1; memRead = !is_wr; memWrite = is_wr; addr = a; wrData = wd;
    for (int c = 0; c <= TMO; c++) begin
      dn = (lat == c);
      to = (lat < 0) && (c == TMO);
      if (c > 0) begin
        addr   = DW'($urandom);
        wrData = DW'($urandom);
      end
      mem_done  = dn;
      mem_rdata = dn ? ((is_wr && hold_n >= 0) ? '0 : rdat) : DW'($urandom);
      hold_in   = dn && (hold_n >= 0);
      step(1'b1, !(dn || to), dn ? res : '0, 1'b1, is_wr, a, wd);
      if (to) exp_to = 1'b1;
      if (dn || to) break;
    end
    valid = 1'b0; mem_done = 1'b0;
    if (lat >= 0 && hold_n >= 0) begin
      for (int h = 0; h <= hold_n; h++) begin
        hold_in   = (h < hold_n);
        mem_done  = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
        step(1'b0, 1'b1, res, 1'b0, 1'b0, '0, '0);
      end
    end
    hold_in = 1'b0; mem_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; hold_in = 1'b0;
    mem_done = 1'b0; addr = '0; wrData = '0; mem_rdata = '0;
    @(posedge clk); #1;
    idle_step();
    rst = 1'b0;
    idle_step();

    do_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, -1);
    idle_step();
    do_access(1'b1, 16'h0020, 16'h1234, 16'h7777, 3, -1);
    idle_step();
    do_access(1'b0, 16'h0040, 16'h0000, 16'hA5A5, 1, 2);
    idle_step();
    misaligned(1'b0, 16'h0011);
    repeat (3) gap();
    do_access(1'b0, 16'h0080, 16'h0000, 16'h0000, -1, -1);
    idle_step();
    do_access(1'b1, 16'h0082, 16'hC0DE, 16'h1111, 2, 1);
    gap();

    for (int i = 0; i < 200; i++) begin
      int kind, lat, hn;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        valid = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = DW'($urandom);
        idle_step();
        valid = 1'b0;
      end else if (kind == 1) begin
        misaligned(1'($urandom_range(0, 1)), DW'($urandom));
      end else begin
        lat = $urandom_range(0, 8);
        if (lat == 8) lat = -1;
        hn = $urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : -1;
        do_access(1'($urandom_range(0, 1)), DW'($urandom) & 16'hFFFE, DW'($urandom),
                  DW'($urandom), lat, hn);
      end
      if ($urandom_range(0, 1) == 1) gap();
    end

    // reset in the 2nd BUSY cycle, then a stray completion
    valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; addr = 16'h0100; wrData = 16'h4242;
    step(1'b1, 1'b1, '0, 1'b1, 1'b0, 16'h0100, 16'h4242);
    step(1'b1, 1'b1, '0, 1'b1, 1'b0, 16'h0100, 16'h4242);
    rst = 1'b1; valid = 1'b0;
    step(1'b1, 1'b1, '0, 1'b1, 1'b0, 16'h0100, 16'h4242);
    exp_align = 1'b0; exp_to = 1'b0;
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'h5555;
    idle_step();
    mem_done = 1'b0;
    idle_step();
    do_access(1'b0, 16'h0200, 16'h0000, 16'h3C3C, 2, -1);
    idle_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
